// File: rtl/core_pkg.sv
// Shared core types for the execute-stage coprocessors: MDU op encoding and iteration count.
// Pure definitions, no logic and no latency.
package core_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_t;

  localparam int MDU_ITER_CYCLES = 32;

  function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration, plus the 33-bit adder the shift-add multiplier borrows.
// Purely combinational, zero latency, no flow control.
module mdu_div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o,
  output logic [32:0] sum_o
);

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    ge      = shifted >= {1'b0, div_i};
    // When ge holds the difference is below the divisor, so 32 bits suffice.
    diff    = shifted[31:0] - div_i;
    rem_o   = ge ? diff : shifted[31:0];
    quo_o   = {quo_i[30:0], ge};
    sum_o   = {1'b0, rem_i} + {1'b0, div_i};
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide responder; 33-cycle iterative latency, 1 cycle for special divides.
// Single-cycle MUL* when MDU_FAST_MUL_EN is defined; no back-pressure on results, gnt_o low while busy.
module mdu
  import core_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  mdu_op_t          op_i,
  input  logic [31:0]      operand_a_i,
  input  logic [31:0]      operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             rvalid_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      opb_q, opb_d;
  logic [31:0]      result_q, result_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  mdu_op_t          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic        accept, last;
  logic        a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic        div_zero, div_ovf;

  logic [31:0] step_rem_in, step_rem, step_quo, quo_fix, rem_fix;
  logic [32:0] step_sum;

  always_comb begin
    accept   = req_i && gnt_o;
    last     = cnt_q == 6'(MDU_ITER_CYCLES - 1);
    a_sgn    = op_i[2] ? !op_i[0] : (op_i == MDU_MULH || op_i == MDU_MULHSU);
    b_sgn    = op_i[2] ? !op_i[0] : (op_i == MDU_MULH);
    a_neg    = a_sgn && operand_a_i[31];
    b_neg    = b_sgn && operand_b_i[31];
    a_abs    = mdu_abs(operand_a_i, a_sgn);
    b_abs    = mdu_abs(operand_b_i, b_sgn);
    div_zero = operand_b_i == 32'd0;
    div_ovf  = !op_i[0] && operand_a_i == 32'h8000_0000 && operand_b_i == 32'hFFFF_FFFF;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [32:0] fa, fb;
  logic [63:0]        fprod;

  always_comb begin
    fa          = {a_sgn && operand_a_i[31], operand_a_i};
    fb          = {b_sgn && operand_b_i[31], operand_b_i};
    fprod       = 64'(fa) * 64'(fb);
    step_rem_in = acc_q[31:0];
  end
`else
  logic [63:0] mul_next, mul_prod;

  always_comb begin
    // Multiplier layout: acc = {partial product, remaining multiplier bits}.
    step_rem_in = (state_q == S_MUL) ? acc_q[63:32] : acc_q[31:0];
    mul_next    = {(acc_q[0] ? step_sum : {1'b0, acc_q[63:32]}), acc_q[31:1]};
    mul_prod    = neg_q ? (~mul_next + 64'd1) : mul_next;
  end
`endif

  mdu_div_step u_step (
    .rem_i (step_rem_in),
    .quo_i (quo_q),
    .div_i (opb_q),
    .rem_o (step_rem),
    .quo_o (step_quo),
    .sum_o (step_sum)
  );

  always_comb begin
    quo_fix = neg_q  ? (~step_quo + 32'd1) : step_quo;
    rem_fix = rneg_q ? (~step_rem + 32'd1) : step_rem;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      op_q     <= MDU_MUL;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!op_i[2]) begin
`ifdef MDU_FAST_MUL_EN
            state_d = S_DONE;
`else
            state_d = S_MUL;
`endif
          end else if (div_zero || div_ovf) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush_i)   state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    result_d = result_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    op_d     = op_q;
    tag_d    = tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = op_i;
          tag_d = tag_i;
          cnt_d = '0;
          if (!op_i[2]) begin
`ifdef MDU_FAST_MUL_EN
            result_d = (op_i == MDU_MUL) ? fprod[31:0] : fprod[63:32];
`else
            acc_d = {32'd0, b_abs};
            opb_d = a_abs;
            neg_d = a_neg ^ b_neg;
`endif
          end else if (div_zero) begin
            result_d = op_i[1] ? operand_a_i : 32'hFFFF_FFFF;
          end else if (div_ovf) begin
            result_d = op_i[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            acc_d  = '0;
            quo_d  = a_abs;
            opb_d  = b_abs;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
          end
        end
      end
`ifndef MDU_FAST_MUL_EN
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 6'd1;
        if (last) result_d = (op_q == MDU_MUL) ? mul_prod[31:0] : mul_prod[63:32];
      end
`endif
      S_DIV: begin
        acc_d = {32'd0, step_rem};
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (last) result_d = op_q[1] ? rem_fix : quo_fix;
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt_o    = (state_q == S_IDLE) && !flush_i && !rst_i;
    rvalid_o = (state_q == S_DONE) && !flush_i;
    busy_o   = (state_q != S_IDLE) && !rvalid_o;
    result_o = result_q;
    tag_o    = tag_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Directed + randomised bench for mdu: scoreboard of expected result/tag/arrival cycle,
// checked by a negedge monitor whenever rvalid_o pulses.
module tb_mdu;
  import core_pkg::*;

  localparam int TAG_W = 5;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = MDU_ITER_CYCLES;
`endif

  logic             clk, rst, req_i, gnt_o, flush_i, rvalid_o, busy_o;
  mdu_op_t          op_i;
  logic [31:0]      operand_a_i, operand_b_i, result_o;
  logic [TAG_W-1:0] tag_i, tag_o;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  mdu #(.TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .tag_i       (tag_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .tag_o       (tag_o),
    .rvalid_o    (rvalid_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rvalid_o === 1'b1) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rvalid observed result=%h tag=%h expected no rvalid", result_o, tag_o);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        assert (result_o === e.res) else begin
          errors++;
          $error("FAIL result observed=%h expected=%h", result_o, e.res);
        end
        checks++;
        assert (tag_o === e.tag) else begin
          errors++;
          $error("FAIL tag observed=%h expected=%h", tag_o, e.tag);
        end
        checks++;
        assert (cyc == e.due) else begin
          errors++;
          $error("FAIL rvalid_cycle observed=%0d expected=%0d", cyc, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (op)
      MDU_MUL:    begin p = ua * ub; return p[31:0]; end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
      MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
      MDU_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      MDU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 32'd0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return MDU_ITER_CYCLES;
  endfunction

  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp, input bit push);
    int n;
    n = 0;
    while (!(gnt_o === 1'b1 && sbq.size() == 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL issue_wait observed=%0d cycles expected<200", n);
    end
    req_i       = 1'b1;
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    tag_i       = tag;
    if (push) sbq.push_back('{exp, tag, cyc + 1 + lat_of(op, a, b)});
    @(posedge clk);
    #1;
    req_i = 1'b0;
  endtask

  initial begin
    mdu_op_t     rop;
    logic [31:0] ra, rb;
    int          n;

    rst = 1'b1; req_i = 1'b0; flush_i = 1'b0; op_i = MDU_MUL;
    operand_a_i = '0; operand_b_i = '0; tag_i = '0;
    #2;
    chk("rst_result", result_o, 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("gnt_after_rst", 32'(gnt_o), 32'd1);

    // DIVU with busy tracked across every iteration cycle
    issue(MDU_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 1'b1);
    for (int i = 0; i < MDU_ITER_CYCLES; i++) begin
      @(negedge clk);
      chk("busy_iter", 32'(busy_o), 32'd1);
    end
    @(negedge clk);
    chk("rvalid_done", 32'(rvalid_o), 32'd1);
    chk("busy_done", 32'(busy_o), 32'd0);

    issue(MDU_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 1'b1);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b1);
    issue(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b1);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b1);
    issue(MDU_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b1);
    issue(MDU_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1'b1);
    issue(MDU_REMU, 32'd5, 32'd0, 5'd12, 32'd5, 1'b1);
    issue(MDU_DIV, 32'hFFFF_FFFD, 32'd0, 5'd13, 32'hFFFF_FFFF, 1'b1);
    issue(MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'd1, 1'b1);
    issue(MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'd0, 1'b1);
    issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFE, 1'b1);
    issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFF, 1'b1);
    issue(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd18, 32'hFFFF_FFEB, 1'b1);

    // Flush in cycle T+10 with a request held; no result may ever appear
    issue(MDU_DIVU, 32'd1000, 32'd3, 5'd19, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1; req_i = 1'b1; op_i = MDU_DIVU;
    #1;
    chk("gnt_in_flush", 32'(gnt_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0; req_i = 1'b0;
    #1;
    chk("gnt_after_flush", 32'(gnt_o), 32'd1);
    chk("busy_after_flush", 32'(busy_o), 32'd0);
    flush_i = 1'b1; req_i = 1'b1;
    #1;
    chk("gnt_idle_flush", 32'(gnt_o), 32'd0);
    @(posedge clk);
    #1;
    chk("busy_idle_flush", 32'(busy_o), 32'd0);
    flush_i = 1'b0; req_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Asynchronous reset in cycle T+20 of a DIV
    issue(MDU_DIV, 32'd1000, 32'd7, 5'd21, 32'd0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_tag", 32'(tag_o), 32'd0);
    chk("midrst_rvalid", 32'(rvalid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_gnt", 32'(gnt_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("gnt_after_midrst", 32'(gnt_o), 32'd1);
    issue(MDU_MULHU, 32'd2, 32'd3, 5'd22, 32'd0, 1'b1);
    issue(MDU_MUL, 32'd2, 32'd3, 5'd23, 32'd6, 1'b1);

    for (int i = 0; i < 12; i++) begin
      rop = mdu_op_t'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom();
      if ($urandom_range(0, 3) == 0) ra = -ra;
      issue(rop, ra, rb, 5'(i), ref_mdu(rop, ra, rb), 1'b1);
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative RV32M multiply/divide unit; the responder side of the execute stage's req/gnt/rvalid coprocessor handshake, the same protocol the execute stage uses to drive the FPU. The unit accepts one operation when idle and returns exactly one result pulse, or none if flushed. The execute stage holds it via `busy_o` and selects `result_o` through its result mux.

## Interface
- `TAG_W`, default 5: width of the pass-through tag (rd address).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in 1: request valid.
- `gnt_o` out 1: ready to accept; transfer occurs when `req_i && gnt_o`.
- `op_i` in 3: `mdu_op_t`, encoding equals RV32M funct3.
- `operand_a_i` in 32: rs1 / dividend.
- `operand_b_i` in 32: rs2 / divisor.
- `tag_i` in `TAG_W`: captured on accept.
- `flush_i` in 1: abort the in-flight operation.
- `result_o` out 32: result, valid while `rvalid_o` is high.
- `tag_o` out `TAG_W`: tag of the current result.
- `rvalid_o` out 1: one-cycle result pulse. There is no back-pressure; the consumer always accepts.
- `busy_o` out 1: an operation is in flight and its result has not yet been delivered.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Registers: 6-bit counter, 64-bit accumulator/remainder, 32-bit quotient/multiplier, sign flags, op, tag.
- `gnt_o = (state==IDLE) && !flush_i && !rst_i`. Requests are never accepted in MUL, DIV or DONE.
- Accept from IDLE, by operation class:
  - MUL\*: the unit captures operands. For signed operands per the op, it stores absolute values plus the result sign. It goes to MUL, or to DONE when `MDU_FAST_MUL_EN` is defined.
  - DIV\*, divide by zero (b==0): go to DONE with the result precomputed. DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - DIV\*, signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF): DIV returns 0x80000000; REM returns 0. Go to DONE.
  - DIV\*, otherwise: go to DIV.
- MUL: shift-add, 1 bit per cycle for 32 cycles. When the counter hits 31, negate if the sign flag is set, then go to DONE.
- DIV: restoring division, 1 quotient bit per cycle for 32 cycles.
  - Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
  - The sign fix is applied on entering DONE.
- Result selection:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV\*: quotient.
  - REM\*: remainder.
- DONE:
  - `rvalid_o = (state==DONE) && !flush_i`; `result_o` and `tag_o` are registered.
  - The unit returns to IDLE unconditionally on the next cycle.
- Flush:
  - `flush_i` in MUL, DIV or DONE forces IDLE on the next edge.
  - No `rvalid_o` is produced for the flushed operation.
  - `flush_i` in IDLE has no effect other than masking `gnt_o`.
- `busy_o = (state!=IDLE) && !rvalid_o`.
- Reset (asynchronous, at any time, including mid-operation):
  - State goes to IDLE; all registers clear.
  - `result_o`=0, `tag_o`=0, `rvalid_o`=0, `busy_o`=0, `gnt_o`=0 while `rst_i` is high; `gnt_o`=1 after release.

## Timing
- Accept at edge T.
- Iterative MUL/DIV: states cover T+1..T+32; `rvalid_o` is high in cycle T+33.
- Fast MUL and special-case DIV: `rvalid_o` is high in cycle T+1.
- Next accept no earlier than the cycle after `rvalid_o`, when `gnt_o` is high again.
- Throughput: one operation per 34 cycles (iterative) or per 2 cycles (fast/special).
- `gnt_o`, `rvalid_o` and `busy_o` are combinational from state and `flush_i` only. None depends on `req_i`.

## Configuration
- `MDU_FAST_MUL_EN` defined: all MUL\* ops use a single-cycle 33x33 signed multiplier (operands sign/zero-extended per op). The result is available at T+1, and the MUL state and shift-add path are not built.
- `MDU_FAST_MUL_EN` undefined: MUL\* ops use the 32-cycle shift-add datapath shared with the division accumulator. Latency is 33 cycles.
- Division is always iterative.

## Structure
- `core_pkg` gets:
  - `mdu_op_t`: MDU_MUL=3'b000, MDU_MULH=001, MDU_MULHSU=010, MDU_MULHU=011, MDU_DIV=100, MDU_DIVU=101, MDU_REM=110, MDU_REMU=111.
  - `MDU_ITER_CYCLES=32`.
- The FSM state enum stays local to `mdu`.
- One sub-module, `mdu_div_step`: combinational single-iteration restoring step. It takes remainder/quotient/divisor and returns the next remainder/quotient. It is reused by the iterative multiplier's add stage when `MDU_FAST_MUL_EN` is undefined.

## Test plan
- DIVU a=100, b=7 accepted at T: `rvalid_o` only at T+33 with `result_o`=14 and `tag_o` equal to the accepted tag. REMU with the same operands gives 2. `busy_o` is high T+1..T+32.
- DIV a=0x80000000, b=0xFFFFFFFF: `rvalid_o` at T+1 with result 0x80000000. REM gives 0. DIV a=-7, b=2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF.
- DIVU a=5, b=0: result 0xFFFFFFFF at T+1. REMU gives 5. DIV a=-3, b=0 gives 0xFFFFFFFF.
- a=b=0xFFFFFFFF:
  - MUL gives 1; MULH gives 0; MULHU gives 0xFFFFFFFE; MULHSU gives 0xFFFFFFFF.
  - Latency is T+1 with `MDU_FAST_MUL_EN` and T+33 without.
- DIVU accepted at T, `flush_i` at T+10: no `rvalid_o` ever; `gnt_o` high at T+11; `busy_o` low at T+11. A `req_i` held during flush is not accepted.
- Reset asserted at T+20 of a DIV: outputs go to 0 immediately. After release, the unit accepts MULHU 2×3 and returns 0 with no residual state.
